uart_reg_bridge: RTL and testbench

- Bus initiator for the register bus. Converts command frames received over UART into single-cycle write/read pulses toward the address decoder and register files.
- Returns read data or an acknowledge byte to the UART transmitter.
- Sits between the UART RX/TX byte interfaces and the SoC address decoder. It is the host-side master of every RGF block.

---
 rtl/uart_reg_bridge.sv | 192 +++++++++++++++++++
 tb/tb_uart_reg_bridge.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: UART command frames to register-bus write/read pulses.
// Ports:
//   clk, rst_n                    : clock, async active-low reset
//   rx_data, rx_valid             : received byte strobe
//   tx_data, tx_valid, tx_ready   : response byte handshake
//   bus_addr, bus_wdata           : bus address / write data (held)
//   bus_wr_en, bus_rd_en          : one-cycle bus pulses
//   bus_rdata                     : read data, sampled while bus_rd_en
//   busy                          : not in IDLE
//   rx_overrun                    : pulse when an rx byte is dropped
// Optional macro UART_BRIDGE_TIMEOUT_EN: inter-byte frame timeout.
module uart_reg_bridge #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic                  bus_wr_en,
    output logic                  bus_rd_en,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  busy,
    output logic                  rx_overrun
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int CW     = $clog2(NBYTES + 1);

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] RSP_K = 8'h4B;
    localparam logic [7:0] RSP_E = 8'h45;

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || TIMEOUT_CYCLES < 2)
    begin : g_bad_cfg
        $error("uart_reg_bridge: illegal parameters");
    end

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        BUS_WR,
        BUS_RD,
        SEND
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  is_wr_q, is_wr_d;
    logic                  ovr_q, ovr_d;

`ifdef UART_BRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    RSP_T    = 8'h54;
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    // Response bytes leave from the top of data_q, MSB first.
    function automatic logic [DATA_WIDTH-1:0] top_byte(input logic [7:0] b);
        return DATA_WIDTH'(b) << (DATA_WIDTH - 8);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            is_wr_q <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_BRIDGE_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            is_wr_q <= is_wr_d;
            ovr_q   <= ovr_d;
`ifdef UART_BRIDGE_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        is_wr_d = is_wr_q;
        ovr_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    unique case (1'b1)
                        (rx_data == CMD_W): begin
                            is_wr_d = 1'b1;
                            state_d = GET_ADDR;
                        end
                        (rx_data == CMD_R): begin
                            is_wr_d = 1'b0;
                            state_d = GET_ADDR;
                        end
                        default: begin
                            data_d  = top_byte(RSP_E);
                            cnt_d   = CW'(1);
                            state_d = SEND;
                        end
                    endcase
                end
            end
            GET_ADDR: begin
                if (rx_valid) begin
                    addr_d  = ADDR_WIDTH'(rx_data);
                    cnt_d   = '0;
                    state_d = is_wr_q ? GET_DATA : BUS_RD;
                end
            end
            GET_DATA: begin
                if (rx_valid) begin
                    wdata_d = DATA_WIDTH'({wdata_q, rx_data});
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CW'(NBYTES - 1)) begin
                        state_d = BUS_WR;
                    end
                end
            end
            BUS_WR: begin
                ovr_d   = rx_valid;
                data_d  = top_byte(RSP_K);
                cnt_d   = CW'(1);
                state_d = SEND;
            end
            BUS_RD: begin
                ovr_d   = rx_valid;
                data_d  = bus_rdata;
                cnt_d   = CW'(NBYTES);
                state_d = SEND;
            end
            SEND: begin
                ovr_d = rx_valid;
                if (tx_ready) begin
                    data_d = data_q << 8;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef UART_BRIDGE_TIMEOUT_EN
        tmo_d = '0;
        if ((state_q == GET_ADDR || state_q == GET_DATA) && !rx_valid) begin
            if (tmo_q == TMO_LAST) begin
                data_d  = top_byte(RSP_T);
                cnt_d   = CW'(1);
                state_d = SEND;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
`endif
    end

    assign tx_data    = data_q[DATA_WIDTH-1 -: 8];
    assign tx_valid   = (state_q == SEND);
    assign bus_wr_en  = (state_q == BUS_WR);
    assign bus_rd_en  = (state_q == BUS_RD);
    assign bus_addr   = addr_q;
    assign bus_wdata  = wdata_q;
    assign busy       = (state_q != IDLE);
    assign rx_overrun = ovr_q;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// tb_uart_reg_bridge: directed frames with hand-computed responses.
// Covers write, read, TX backpressure, bad command, overrun, reset.
module tb_uart_reg_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [7:0]  bus_addr;
    logic        bus_wr_en;
    logic        bus_rd_en;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        busy;
    logic        rx_overrun;
    logic [31:0] rd_val;

    int checks   = 0;
    int failures = 0;

    logic [7:0] tx_q[$];
    int wr_cnt = 0, rd_cnt = 0, ovr_cnt = 0;
    int excl_err = 0, stab_err = 0;
    logic prev_bus = 1'b0, prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic stall_mode = 1'b0;
    int stall_n = 0;

    always #5 clk = ~clk;

    uart_reg_bridge #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .bus_addr(bus_addr),
        .bus_wr_en(bus_wr_en),
        .bus_rd_en(bus_rd_en),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .busy(busy),
        .rx_overrun(rx_overrun)
    );

    assign bus_rdata = bus_rd_en ? rd_val : 32'h0;

    // TX sink: either always ready, or 5 stalled cycles per byte.
    always @(posedge clk) begin
        #1;
        if (!stall_mode) begin
            tx_ready = 1'b1;
        end else if (tx_ready) begin
            tx_ready = 1'b0;
            stall_n  = 0;
        end else if (tx_valid) begin
            if (stall_n == 4) tx_ready = 1'b1;
            else stall_n++;
        end
    end

    always @(negedge clk) begin
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
        if (bus_wr_en) wr_cnt++;
        if (bus_rd_en) rd_cnt++;
        if (rx_overrun) ovr_cnt++;
        if ((bus_wr_en && bus_rd_en) ||
            ((bus_wr_en || bus_rd_en) && prev_bus)) excl_err++;
        if (prev_hold && tx_valid && tx_data !== prev_data) stab_err++;
        prev_bus  = bus_wr_en || bus_rd_en;
        prev_hold = tx_valid && !tx_ready;
        prev_data = tx_data;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk);
            #1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic chk_tx(input string tag, input int base, input int n,
                          input logic [31:0] exp);
        logic [31:0] e;
        e = exp;
        chk({tag, "_n"}, tx_q.size() - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i < tx_q.size())
                chk($sformatf("%s_b%0d", tag, i), {24'd0, tx_q[base + i]},
                    {24'd0, e[8*(n-1-i) +: 8]});
        end
    endtask

    int w0, r0, t0, o0;

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rd_val   = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txv", {31'd0, tx_valid}, 0);
        chk("rst_txd", {24'd0, tx_data}, 0);
        chk("rst_bus", {30'd0, bus_wr_en, bus_rd_en}, 0);
        chk("rst_addr", {24'd0, bus_addr}, 0);
        chk("rst_wdata", bus_wdata, 0);
        chk("rst_busy", {30'd0, busy, rx_overrun}, 0);
        rst_n = 1'b1;

        // Write 57 04 00000003
        w0 = wr_cnt; t0 = tx_q.size();
        send_byte(8'h57); send_byte(8'h04);
        send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h03);
        chk("wr_pulse", {31'd0, bus_wr_en}, 1);
        chk("wr_addr", {24'd0, bus_addr}, 32'h04);
        chk("wr_data", bus_wdata, 32'h00000003);
        wait_idle("wr_idle", 50);
        chk("wr_cnt", wr_cnt - w0, 1);
        chk_tx("wr_tx", t0, 1, 32'h4B);
        chk("wr_hold", bus_wdata, 32'h00000003);

        // Read 52 00 -> 0000002D
        rd_val = 32'h0000002D;
        r0 = rd_cnt; t0 = tx_q.size();
        send_byte(8'h52); send_byte(8'h00);
        chk("rd_pulse", {31'd0, bus_rd_en}, 1);
        chk("rd_addr", {24'd0, bus_addr}, 32'h00);
        wait_idle("rd_idle", 50);
        chk("rd_cnt", rd_cnt - r0, 1);
        chk_tx("rd_tx", t0, 4, 32'h0000002D);

        // Read with TX backpressure
        rd_val = 32'hA1B2C3D4;
        stall_mode = 1'b1;
        w0 = wr_cnt; r0 = rd_cnt; t0 = tx_q.size();
        send_byte(8'h52); send_byte(8'h10);
        wait_idle("st_idle", 200);
        chk("st_rd", rd_cnt - r0, 1);
        chk("st_wr", wr_cnt - w0, 0);
        chk("st_stable", stab_err, 0);
        chk_tx("st_tx", t0, 4, 32'hA1B2C3D4);
        stall_mode = 1'b0;

        // Bad command, then a normal write
        w0 = wr_cnt; r0 = rd_cnt; t0 = tx_q.size();
        send_byte(8'h41);
        wait_idle("bad_idle", 50);
        chk("bad_bus", (wr_cnt - w0) + (rd_cnt - r0), 0);
        chk_tx("bad_tx", t0, 1, 32'h45);
        t0 = tx_q.size();
        send_byte(8'h57); send_byte(8'h22);
        send_byte(8'hDE); send_byte(8'hAD);
        send_byte(8'hBE); send_byte(8'hEF);
        chk("bw_pulse", {31'd0, bus_wr_en}, 1);
        chk("bw_addr", {24'd0, bus_addr}, 32'h22);
        chk("bw_data", bus_wdata, 32'hDEADBEEF);
        wait_idle("bw_idle", 50);
        chk("bw_cnt", wr_cnt - w0, 1);
        chk_tx("bw_tx", t0, 1, 32'h4B);

        // rx byte during SEND is dropped
        rd_val = 32'h01020304;
        stall_mode = 1'b1;
        o0 = ovr_cnt; r0 = rd_cnt; t0 = tx_q.size();
        send_byte(8'h52); send_byte(8'h05);
        repeat (3) @(posedge clk);
        send_byte(8'h57);
        wait_idle("ov_idle", 200);
        stall_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("ov_busy", {31'd0, busy}, 0);
        chk("ov_cnt", ovr_cnt - o0, 1);
        chk("ov_rd", rd_cnt - r0, 1);
        chk_tx("ov_tx", t0, 4, 32'h01020304);

        // Reset in the middle of GET_DATA
        w0 = wr_cnt; t0 = tx_q.size();
        send_byte(8'h57); send_byte(8'h30);
        send_byte(8'h11); send_byte(8'h22);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_busy", {31'd0, busy}, 0);
        chk("mr_addr", {24'd0, bus_addr}, 0);
        chk("mr_wdata", bus_wdata, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("mr_wr", wr_cnt - w0, 0);
        chk("mr_tx", tx_q.size() - t0, 0);
        chk("mr_idle", {31'd0, busy}, 0);

`ifdef UART_BRIDGE_TIMEOUT_EN
        w0 = wr_cnt; t0 = tx_q.size();
        send_byte(8'h57); send_byte(8'h08); send_byte(8'hAA);
        wait_idle("to_idle", 300);
        chk("to_wr", wr_cnt - w0, 0);
        chk_tx("to_tx", t0, 1, 32'h54);
`endif

        chk("bus_excl", excl_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
